l1c_axi_rd_arbiter: RTL

//  Shares the CPU wrapper's single AXI read-master port between the L1 I-cache and L1 D-cache line refills.

---
 rtl/l1c_arb_pkg.sv | 12 +
 rtl/l1c_arb_pick.sv | 13 +
 rtl/l1c_axi_rd_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/l1c_arb_pkg.sv
// rtl/l1c_arb_pkg.sv - shared state type, default IDs and AXI constants for the L1C read arbiter
package l1c_arb_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} arb_state_t;

  localparam logic [3:0] I_ID_DEF       = 4'd0;
  localparam logic [3:0] D_ID_DEF       = 4'd1;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/l1c_arb_pick.sv
// rtl/l1c_arb_pick.sv - combinational I/D refill winner select; rr_ptr=1 prefers the D-cache
module l1c_arb_pick (
  input  logic i_req,
  input  logic d_req,
  input  logic rr_ptr,
  output logic gnt_valid,
  output logic gnt_d
);

  assign gnt_valid = i_req | d_req;
  assign gnt_d     = d_req & (rr_ptr | ~i_req);

endmodule

// File: rtl/l1c_axi_rd_arbiter.sv
// rtl/l1c_axi_rd_arbiter.sv - shares one AXI read master between I/D line refills (4-beat INCR bursts)
// L1C_ARB_RR_EN selects round-robin arbitration; otherwise D-cache has fixed priority.
module l1c_axi_rd_arbiter
  import l1c_arb_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter int         BEATS  = 4,
  parameter logic [3:0] I_ID   = I_ID_DEF,
  parameter logic [3:0] D_ID   = D_ID_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic              i_rlast,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_rvalid,
  output logic              d_rlast,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata_o,
  output logic [3:0]        ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [3:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [3:0]        RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              err_o
);

  localparam int                CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]     LAST_CNT  = CW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hf);

  arb_state_t    state, state_nx;
  logic          grant_d;
  logic [CW-1:0] cnt;
  logic          pick_valid, pick_d, rr_ptr;
  logic          grant_now, beat, id_ok;

  assign grant_now = (state == IDLE) && pick_valid;
  assign beat      = (state == DATA) && RVALID;
  assign id_ok     = (RID == ARID);

  assign ARLEN   = 4'(BEATS - 1);
  assign ARSIZE  = AXI_SIZE_4B;
  assign ARBURST = AXI_BURST_INCR;
  assign rdata_o = RDATA;

  l1c_arb_pick u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
    .rr_ptr    (rr_ptr),
    .gnt_valid (pick_valid),
    .gnt_d     (pick_d)
  );

`ifdef L1C_ARB_RR_EN
  // Points at the requester that was not granted last; D wins first after reset.
  logic rr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_q <= 1'b1;
    else if (grant_now) rr_q <= ~pick_d;
  end
  assign rr_ptr = rr_q;
`else
  assign rr_ptr = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ARADDR  <= '0;
      ARID    <= '0;
      grant_d <= 1'b0;
      cnt     <= '0;
      err_o   <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant_now) begin
        ARADDR  <= (pick_d ? d_addr : i_addr) & LINE_MASK;
        ARID    <= pick_d ? D_ID : I_ID;
        grant_d <= pick_d;
        cnt     <= '0;
      end
      // Foreign-ID beats are still consumed and counted, only the forward is suppressed.
      if (beat) begin
        cnt <= cnt + CW'(1);
        if (!id_ok || (RRESP != AXI_RESP_OKAY) || (RLAST && (cnt != LAST_CNT)))
          err_o <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ARVALID  = 1'b0;
    RREADY   = 1'b0;
    i_rvalid = 1'b0;
    i_rlast  = 1'b0;
    i_done   = 1'b0;
    d_rvalid = 1'b0;
    d_rlast  = 1'b0;
    d_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_nx = ADDR;
      end
      ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nx = DATA;
      end
      DATA: begin
        RREADY = 1'b1;
        if (RVALID && id_ok) begin
          i_rvalid = ~grant_d;
          d_rvalid = grant_d;
          i_rlast  = ~grant_d & RLAST;
          d_rlast  = grant_d & RLAST;
        end
        if (RVALID && RLAST) state_nx = DONE;
      end
      DONE: begin
        i_done   = ~grant_d;
        d_done   = grant_d;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
